// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and pipeline sizing helper for the pipelined adder.
package alu_pkg;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

    // Returns 0 when the width does not split evenly so the caller can reject the configuration.
    function automatic int chunk_width(input int width, input int stages);
        if (stages <= 0 || (width % stages) != 0) begin
            return 0;
        end
        return width / stages;
    endfunction

endpackage

// File: rtl/Full_Adder.sv
// Single-bit full adder cell, the building block of every adder slice.
module Full_Adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/adder_slice.sv
// Combinational CW-bit ripple adder built from chained Full_Adder cells.
module adder_slice #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] num_1,
    input  logic [CW-1:0] num_2,
    input  logic          c,
    output logic [CW-1:0] sum,
    output logic          carry
);

    // Each bit owns its own carry nets so the ripple is a plain chain of distinct signals.
    for (genvar i = 0; i < CW; i++) begin : g_bit
        logic ci;
        logic co;
        if (i == 0) begin : g_first
            assign ci = c;
        end else begin : g_next
            assign ci = g_bit[i-1].co;
        end
        Full_Adder u_fa (
            .a     (num_1[i]),
            .b     (num_2[i]),
            .c     (ci),
            .sum   (sum[i]),
            .carry (co)
        );
    end

    assign carry = g_bit[CW-1].co;

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract unit with the carry chain split into STAGES registered chunks.
// Define ADDER_OVERFLOW_FLAG_EN to add the signed-overflow output ovf.
module pipelined_adder
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num_1,
    input  logic [WIDTH-1:0] num_2,
    input  logic             c,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef ADDER_OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = chunk_width(WIDTH, STAGES);

    if (CW == 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    // Per-stage registers; operands shift down by CW and finished chunks enter the sum from the top.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];

    logic [WIDTH-1:0] op_a [STAGES];
    logic [WIDTH-1:0] op_b [STAGES];
    logic [WIDTH-1:0] part [STAGES];
    logic             op_c [STAGES];
    logic             op_v [STAGES];
    logic [CW-1:0]    chunk_sum   [STAGES];
    logic             chunk_carry [STAGES];
    logic [STAGES:0]  rdy;

    always_comb begin
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !v_q[k] || rdy[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign op_a[k] = num_1;
            assign op_b[k] = (sub == ALU_OP_ADD) ? num_2 : ~num_2;
            assign op_c[k] = (sub == ALU_OP_SUB) ? 1'b1 : c;
            assign op_v[k] = in_valid;
            assign part[k] = '0;
        end else begin : g_body
            assign op_a[k] = a_q[k-1];
            assign op_b[k] = b_q[k-1];
            assign op_c[k] = c_q[k-1];
            assign op_v[k] = v_q[k-1];
            assign part[k] = s_q[k-1];
        end

        adder_slice #(.CW(CW)) u_slice (
            .num_1 (op_a[k][CW-1:0]),
            .num_2 (op_b[k][CW-1:0]),
            .c     (op_c[k]),
            .sum   (chunk_sum[k]),
            .carry (chunk_carry[k])
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end else if (rdy[k]) begin
                v_q[k] <= op_v[k];
                if (op_v[k]) begin
                    a_q[k] <= op_a[k] >> CW;
                    b_q[k] <= op_b[k] >> CW;
                    s_q[k] <= (WIDTH'(chunk_sum[k]) << (WIDTH - CW)) | (part[k] >> CW);
                    c_q[k] <= chunk_carry[k];
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign carry     = c_q[STAGES-1];

`ifdef ADDER_OVERFLOW_FLAG_EN
    // Carry into the MSB is recovered from the MSB operand bits and the MSB result bit.
    logic ovf_next;
    logic ovf_q;

    assign ovf_next = (op_a[STAGES-1][CW-1] ^ op_b[STAGES-1][CW-1] ^ chunk_sum[STAGES-1][CW-1])
                      ^ chunk_carry[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (rdy[STAGES-1] && op_v[STAGES-1]) begin
            ovf_q <= ovf_next;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
